data_mux_sequencer: RTL and testbench

- Time-division scheduler that drives the output_select and gating of the stream mux datapath (data_mux_impl).
- Walks round-robin over the enabled inputs and dwells on each for a programmed number of accepted output beats.
- Inserts a fixed gap (mux gated, idle words emitted) at every switch.
- Handles fast-control link reset and per-slot starvation timeout. Sits beside the mux; its select feeds the mux instead of the static register field.

---
 rtl/data_mux_pkg.sv | 22 ++
 rtl/rr_next_select.sv | 16 +
 rtl/data_mux_sequencer.sv | 116 +++++++++++
 tb/tb_data_mux_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/data_mux_pkg.sv
// data_mux_pkg: shared states, widths and round-robin helper for the stream mux scheduler
package data_mux_pkg;
    typedef enum logic [1:0] {IDLE, GAP, HOLD} seq_state_t;
    localparam int SEL_W = 4;
    localparam int MAX_INPUTS = 16;
    function automatic logic [SEL_W-1:0] next_enabled(input logic [MAX_INPUTS-1:0] mask, input logic [SEL_W-1:0] cur);
        logic [SEL_W-1:0] lo;
        logic [SEL_W-1:0] hi;
        logic hv;
        lo = cur;
        hi = cur;
        hv = 1'b0;
        for (int i = MAX_INPUTS - 1; i >= 0; i--) begin
            if (mask[i]) lo = SEL_W'(i);
            if (mask[i] && i > int'(cur)) begin
                hi = SEL_W'(i);
                hv = 1'b1;
            end
        end
        return hv ? hi : lo;
    endfunction
endpackage

// File: rtl/rr_next_select.sv
// rr_next_select: combinational round-robin successor and lowest enabled index of a request mask
module rr_next_select
    import data_mux_pkg::*;
#(
    parameter int N_INPUTS = 2
) (
    input  logic [N_INPUTS-1:0] i_mask,
    input  logic [SEL_W-1:0]    i_cur,
    output logic [SEL_W-1:0]    o_next,
    output logic [SEL_W-1:0]    o_lowest
);
    logic [MAX_INPUTS-1:0] w_mask;
    assign w_mask = MAX_INPUTS'(i_mask);
    assign o_next = next_enabled(w_mask, i_cur);
    assign o_lowest = (w_mask == '0) ? '0 : next_enabled(w_mask, SEL_W'(MAX_INPUTS - 1));
endmodule

// File: rtl/data_mux_sequencer.sv
// data_mux_sequencer: time-division scheduler driving the stream mux select and gate
module data_mux_sequencer
    import data_mux_pkg::*;
#(
    parameter int N_INPUTS = 2,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] enable_mask,
    input  logic [15:0]         dwell_words,
    input  logic                beat_accept,
    input  logic                fc_linkReset,
    output logic [SEL_W-1:0]    output_select,
    output logic                mux_gate,
    output logic                switch_pulse,
    output logic                timeout_pulse,
    output logic [15:0]         slot_beats
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    seq_state_t r_state;
    logic [SEL_W-1:0] r_sel;
    logic r_gate, r_sw, r_to;
    logic [15:0] r_beats;
    logic [GW-1:0] r_gap_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [MAX_INPUTS-1:0] w_mask;
    logic [SEL_W-1:0] w_next, w_lowest;
    logic [15:0] w_beats_inc, w_dwell;
    logic w_any, w_done, w_timeout, w_drop, w_switch;
    rr_next_select #(.N_INPUTS(N_INPUTS)) u_rr (
        .i_mask   (enable_mask),
        .i_cur    (r_sel),
        .o_next   (w_next),
        .o_lowest (w_lowest)
    );
    assign w_mask = MAX_INPUTS'(enable_mask);
    assign w_any = |enable_mask;
    assign w_beats_inc = (beat_accept && r_beats != 16'hFFFF) ? r_beats + 16'd1 : r_beats;
    assign w_dwell = (dwell_words == 16'd0) ? 16'd1 : dwell_words;
    // the final beat closes the slot in the cycle it is accepted
    assign w_done = beat_accept && w_beats_inc >= w_dwell;
    assign w_timeout = !beat_accept && r_to_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign w_drop = !w_mask[r_sel];
    assign w_switch = w_done || w_timeout || w_drop;
    // scheduler state machine; link reset re-seeds the schedule from the lowest enabled input
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel <= '0;
            r_gate <= 1'b1;
            r_sw <= 1'b0;
            r_to <= 1'b0;
            r_beats <= '0;
            r_gap_cnt <= '0;
            r_to_cnt <= '0;
        end else begin
            r_sw <= 1'b0;
            r_to <= 1'b0;
            if (fc_linkReset) begin
                r_sel <= w_lowest;
                r_gate <= 1'b1;
                r_beats <= '0;
                r_gap_cnt <= '0;
                r_to_cnt <= '0;
                r_state <= w_any ? GAP : IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_gate <= 1'b1;
                        if (w_any) begin
                            r_sel <= w_lowest;
                            r_gap_cnt <= '0;
                            r_state <= GAP;
                        end
                    end
                    GAP: begin
                        r_gate <= 1'b1;
                        if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                            r_state <= HOLD;
                            r_gate <= 1'b0;
                            r_sw <= 1'b1;
                            r_beats <= '0;
                            r_to_cnt <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + GW'(1);
                        end
                    end
                    HOLD: begin
                        r_beats <= w_beats_inc;
                        r_to_cnt <= beat_accept ? '0 : r_to_cnt + TW'(1);
                        if (w_switch) begin
                            r_gate <= 1'b1;
                            r_to <= w_timeout;
                            r_gap_cnt <= '0;
                            if (w_any) begin
                                r_sel <= w_next;
                                r_state <= GAP;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
    assign output_select = r_sel;
    assign mux_gate = r_gate;
    assign switch_pulse = r_sw;
    assign timeout_pulse = r_to;
    assign slot_beats = r_beats;
endmodule

// File: tb/tb_data_mux_sequencer.sv
// tb_data_mux_sequencer: directed vector table plus hand sequences for the mux scheduler
module tb_data_mux_sequencer;
    typedef struct {
        logic        rst;
        logic [3:0]  mask;
        logic [15:0] dwell;
        logic        beat;
        logic        lr;
        logic [3:0]  sel;
        logic        gate;
        logic        sw;
        logic        to;
        logic [15:0] beats;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] enable_mask = '0;
    logic [15:0] dwell_words = '0;
    logic beat_accept = 1'b0;
    logic fc_linkReset = 1'b0;
    logic [3:0] output_select;
    logic mux_gate, switch_pulse, timeout_pulse;
    logic [15:0] slot_beats;
    int total = 0;
    int bad = 0;
    data_mux_sequencer #(.N_INPUTS(4), .GAP_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_mask   (enable_mask),
        .dwell_words   (dwell_words),
        .beat_accept   (beat_accept),
        .fc_linkReset  (fc_linkReset),
        .output_select (output_select),
        .mux_gate      (mux_gate),
        .switch_pulse  (switch_pulse),
        .timeout_pulse (timeout_pulse),
        .slot_beats    (slot_beats)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask
    task automatic step(input logic [3:0] m, input logic [15:0] d, input logic b, input logic l);
        enable_mask = m;
        dwell_words = d;
        beat_accept = b;
        fc_linkReset = l;
        tick();
    endtask
    task automatic rst_seq();
        reset = 1'b1;
        step(4'b0000, 16'd0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask
    vec_t tv[12];
    logic [3:0] seq[4];
    int r, k, to_seen;
    initial begin
        tv[0]  = '{1'b1, 4'b0000, 16'd2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0};
        tv[1]  = '{1'b0, 4'b0000, 16'd2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0};
        tv[2]  = '{1'b0, 4'b0000, 16'd2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0};
        tv[3]  = '{1'b0, 4'b0101, 16'd2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0};
        tv[4]  = '{1'b0, 4'b0101, 16'd2, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0};
        tv[5]  = '{1'b0, 4'b0101, 16'd2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0};
        tv[6]  = '{1'b0, 4'b0101, 16'd2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0};
        tv[7]  = '{1'b0, 4'b0101, 16'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'd0};
        tv[8]  = '{1'b0, 4'b0101, 16'd2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd1};
        tv[9]  = '{1'b0, 4'b0101, 16'd2, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 16'd2};
        tv[10] = '{1'b1, 4'b0101, 16'd2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0};
        tv[11] = '{1'b0, 4'b0101, 16'd2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0};
        for (int i = 0; i < 12; i++) begin
            reset = tv[i].rst;
            step(tv[i].mask, tv[i].dwell, tv[i].beat, tv[i].lr);
            chk($sformatf("vec%0d sel", i), 32'(output_select), 32'(tv[i].sel));
            chk($sformatf("vec%0d gate", i), 32'(mux_gate), 32'(tv[i].gate));
            chk($sformatf("vec%0d sw", i), 32'(switch_pulse), 32'(tv[i].sw));
            chk($sformatf("vec%0d to", i), 32'(timeout_pulse), 32'(tv[i].to));
            chk($sformatf("vec%0d beats", i), 32'(slot_beats), 32'(tv[i].beats));
        end
        // dwell 3 over mask 1011, beat offered every cycle: 4 gated then 3 ungated per slot
        seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd3; seq[3] = 4'd0;
        rst_seq();
        for (int e = 0; e < 28; e++) begin
            step(4'b1011, 16'd3, 1'b1, 1'b0);
            r = e % 7;
            k = e / 7;
            chk($sformatf("rr e%0d sel", e), 32'(output_select), 32'(seq[k]));
            chk($sformatf("rr e%0d gate", e), 32'(mux_gate), 32'(r < 4));
            chk($sformatf("rr e%0d sw", e), 32'(switch_pulse), 32'(r == 4));
            chk($sformatf("rr e%0d beats", e), 32'(slot_beats), (r >= 4) ? 32'(r - 4) : (k == 0 ? 32'd0 : 32'd3));
        end
        // dwell 0 acts as 1 on a lone input 2
        rst_seq();
        for (int e = 0; e < 15; e++) begin
            step(4'b0100, 16'd0, 1'b1, 1'b0);
            r = e % 5;
            chk($sformatf("d0 e%0d sel", e), 32'(output_select), 32'd2);
            chk($sformatf("d0 e%0d gate", e), 32'(mux_gate), 32'(r < 4));
            chk($sformatf("d0 e%0d beats", e), 32'(slot_beats), (r == 4 || e < 4) ? 32'd0 : 32'd1);
        end
        // starvation timeout on input 1 after 1024 idle HOLD cycles
        rst_seq();
        to_seen = 0;
        for (int e = 0; e < 1030; e++) begin
            step(4'b0110, 16'd5, 1'b0, 1'b0);
            if (e < 1028 && timeout_pulse) to_seen++;
            if (e == 4) chk("to hold sel", 32'(output_select), 32'd1);
            if (e == 1027) chk("to pre gate", 32'(mux_gate), 32'd0);
            if (e == 1028) begin
                chk("to pulse", 32'(timeout_pulse), 32'd1);
                chk("to gate", 32'(mux_gate), 32'd1);
                chk("to sel", 32'(output_select), 32'd2);
            end
            if (e == 1029) chk("to pulse once", 32'(timeout_pulse), 32'd0);
        end
        chk("to early", 32'(to_seen), 32'd0);
        // a beat on the 1023rd idle cycle restarts the count
        rst_seq();
        to_seen = 0;
        for (int e = 0; e < 2052; e++) begin
            step(4'b0110, 16'd5, e == 1027, 1'b0);
            if (e < 2051 && timeout_pulse) to_seen++;
            if (e == 1027) chk("tr beats", 32'(slot_beats), 32'd1);
            if (e == 1028) chk("tr gate", 32'(mux_gate), 32'd0);
            if (e == 2050) chk("tr pre gate", 32'(mux_gate), 32'd0);
            if (e == 2051) begin
                chk("tr pulse", 32'(timeout_pulse), 32'd1);
                chk("tr sel", 32'(output_select), 32'd2);
            end
        end
        chk("tr early", 32'(to_seen), 32'd0);
        // link reset in mid-HOLD on input 3, then link reset against final dwell beat
        rst_seq();
        for (int e = 0; e < 5; e++) step(4'b1010, 16'd1, 1'b0, 1'b0);
        chk("lr hold1 sel", 32'(output_select), 32'd1);
        chk("lr hold1 sw", 32'(switch_pulse), 32'd1);
        step(4'b1010, 16'd1, 1'b1, 1'b0);
        chk("lr adv sel", 32'(output_select), 32'd3);
        for (int e = 0; e < 4; e++) step(4'b1010, 16'd3, 1'b0, 1'b0);
        chk("lr hold3 gate", 32'(mux_gate), 32'd0);
        chk("lr hold3 sel", 32'(output_select), 32'd3);
        step(4'b1010, 16'd3, 1'b1, 1'b0);
        chk("lr beats1", 32'(slot_beats), 32'd1);
        step(4'b1010, 16'd3, 1'b0, 1'b1);
        chk("lr sel", 32'(output_select), 32'd1);
        chk("lr gate", 32'(mux_gate), 32'd1);
        chk("lr beats", 32'(slot_beats), 32'd0);
        for (int e = 0; e < 3; e++) step(4'b1010, 16'd3, 1'b0, 1'b0);
        chk("lr gap gate", 32'(mux_gate), 32'd1);
        step(4'b1010, 16'd3, 1'b0, 1'b0);
        chk("lr rehold gate", 32'(mux_gate), 32'd0);
        chk("lr rehold sw", 32'(switch_pulse), 32'd1);
        step(4'b1010, 16'd1, 1'b1, 1'b1);
        chk("lr win sel", 32'(output_select), 32'd1);
        chk("lr win beats", 32'(slot_beats), 32'd0);
        chk("lr win gate", 32'(mux_gate), 32'd1);
        // enable drop of granted input, then whole mask cleared
        rst_seq();
        for (int e = 0; e < 5; e++) step(4'b1011, 16'd5, 1'b0, 1'b0);
        chk("ed hold sel", 32'(output_select), 32'd0);
        step(4'b1011, 16'd5, 1'b1, 1'b0);
        chk("ed beats1", 32'(slot_beats), 32'd1);
        step(4'b1010, 16'd5, 1'b0, 1'b0);
        chk("ed gate", 32'(mux_gate), 32'd1);
        chk("ed sel", 32'(output_select), 32'd1);
        step(4'b1010, 16'd5, 1'b1, 1'b0);
        chk("ed no count", 32'(slot_beats), 32'd1);
        for (int e = 0; e < 3; e++) step(4'b1010, 16'd5, 1'b0, 1'b0);
        chk("ed rehold sw", 32'(switch_pulse), 32'd1);
        step(4'b0000, 16'd5, 1'b0, 1'b0);
        chk("ed idle gate", 32'(mux_gate), 32'd1);
        chk("ed idle sel", 32'(output_select), 32'd1);
        step(4'b0000, 16'd5, 1'b0, 1'b0);
        chk("ed idle hold", 32'(output_select), 32'd1);
        step(4'b0100, 16'd5, 1'b0, 1'b0);
        chk("ed wake sel", 32'(output_select), 32'd2);
        chk("ed wake gate", 32'(mux_gate), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
